// File: rtl/display_pkg.sv
// Shared types and the seven-segment decode table for the display driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

   typedef logic [3:0] digit_t;
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'h7F;

   localparam seg_t HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seven_seg
   import display_pkg::*;
(
   input  digit_t digit,
   output seg_t   seg
);

   assign seg = HEX_SEG[digit];

endmodule

// File: rtl/dual_digit_display_driver.sv
// Two-digit time-multiplexed common-anode seven-segment driver with shadow
// registers, per-slot dead time and optional leading-zero blanking.
module dual_digit_display_driver
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter bit          LATCH_ALWAYS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit0_in,
   input  logic [3:0] digit1_in,
   input  logic       latch,
   input  logic       blank_leading_zero,
   output logic [6:0] seg_n,
   output logic [1:0] an_n,
   output logic       dp_n,
   output logic       slot_tick
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t SLOT_LAST = cnt_t'(REFRESH_DIV - 1);
   localparam cnt_t BLANK_END = cnt_t'(BLANK_CYCLES);

   digit_t shadow0_q, shadow0_d;
   digit_t shadow1_q, shadow1_d;
   cnt_t   slot_cnt_q, slot_cnt_d;
   logic   sel_q, sel_d;
   logic   tick_d;

   seg_t       seg_q, seg_d;
   logic [1:0] an_q, an_d;
   logic       dp_q;
   logic       tick_q;

   digit_t cur_digit;
   seg_t   cur_seg;

   // Next-state for shadow registers, slot counter and digit select.
   always_comb begin
      shadow0_d  = shadow0_q;
      shadow1_d  = shadow1_q;
      slot_cnt_d = slot_cnt_q + cnt_t'(1);
      sel_d      = sel_q;
      tick_d     = 1'b0;
      if (latch || LATCH_ALWAYS) begin
         shadow0_d = digit0_in;
         shadow1_d = digit1_in;
      end
      if (slot_cnt_q == SLOT_LAST) begin
         slot_cnt_d = '0;
         sel_d      = ~sel_q;
         tick_d     = 1'b1;
      end
   end

   // Outputs derive from post-update state so a latch on a wrap edge shows at once.
   assign cur_digit = sel_d ? shadow1_d : shadow0_d;

   hex_to_seven_seg u_dec (
      .digit (cur_digit),
      .seg   (cur_seg)
   );

   always_comb begin
      seg_d = SEG_OFF;
      an_d  = 2'b11;
      if (slot_cnt_d < BLANK_END) begin
         seg_d = SEG_OFF;
         an_d  = 2'b11;
      end else if (sel_d && blank_leading_zero && (shadow1_d == 4'd0)) begin
         seg_d = SEG_OFF;
         an_d  = 2'b11;
      end else begin
         seg_d = cur_seg;
         an_d  = ~(2'b01 << sel_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow0_q  <= '0;
         shadow1_q  <= '0;
         slot_cnt_q <= '0;
         sel_q      <= 1'b0;
         seg_q      <= SEG_OFF;
         an_q       <= 2'b11;
         dp_q       <= 1'b1;
         tick_q     <= 1'b0;
      end else begin
         shadow0_q  <= shadow0_d;
         shadow1_q  <= shadow1_d;
         slot_cnt_q <= slot_cnt_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         dp_q       <= 1'b1;
         tick_q     <= tick_d;
      end
   end

   assign seg_n     = seg_q;
   assign an_n      = an_q;
   assign dp_n      = dp_q;
   assign slot_tick = tick_q;

endmodule

// File: tb/tb_dual_digit_display_driver.sv
// Directed bench for dual_digit_display_driver with REFRESH_DIV = 4, BLANK_CYCLES = 1;
// expected outputs are queued when each step is driven and checked after the edge.
module tb_dual_digit_display_driver;

   localparam int unsigned RDIV  = 4;
   localparam int unsigned BLANK = 1;

   localparam logic [6:0] HEX_EXP [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct {
      logic [6:0] seg;
      logic [1:0] an;
      logic       dp;
      logic       tick;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] digit0_in = '0;
   logic [3:0] digit1_in = '0;
   logic       latch = 1'b0;
   logic       blank_leading_zero = 1'b0;
   logic [6:0] seg_n;
   logic [1:0] an_n;
   logic       dp_n;
   logic       slot_tick;

   exp_t        sb_q [$];
   int          tests = 0;
   int          fails = 0;
   int unsigned n    = 0;
   logic [3:0]  m_sh0 = '0;
   logic [3:0]  m_sh1 = '0;

   dual_digit_display_driver #(
      .REFRESH_DIV  (RDIV),
      .BLANK_CYCLES (BLANK),
      .LATCH_ALWAYS (1'b0)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .digit0_in          (digit0_in),
      .digit1_in          (digit1_in),
      .latch              (latch),
      .blank_leading_zero (blank_leading_zero),
      .seg_n              (seg_n),
      .an_n               (an_n),
      .dp_n               (dp_n),
      .slot_tick          (slot_tick)
   );

   always #5 clk = ~clk;

   // n counts edges since the last reset edge; slot position and digit follow from it.
   task automatic step(input bit r, input bit l, input logic [3:0] a, input logic [3:0] b,
                       input bit z, input string tag);
      exp_t        e;
      exp_t        got;
      int unsigned slot;
      bit          s;
      @(negedge clk);
      rst                = r;
      latch              = l;
      digit0_in          = a;
      digit1_in          = b;
      blank_leading_zero = z;
      e.tag  = tag;
      e.dp   = 1'b1;
      e.seg  = 7'h7F;
      e.an   = 2'b11;
      e.tick = 1'b0;
      if (r) begin
         n     = 0;
         m_sh0 = '0;
         m_sh1 = '0;
      end else begin
         if (l) begin
            m_sh0 = a;
            m_sh1 = b;
         end
         n++;
         slot   = n % RDIV;
         s      = ((n / RDIV) % 2) == 1;
         e.tick = (slot == 0);
         if (slot >= BLANK && !(s && z && m_sh1 == 4'd0)) begin
            e.an  = s ? 2'b01 : 2'b10;
            e.seg = HEX_EXP[s ? m_sh1 : m_sh0];
         end
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      tests++;
      assert (seg_n === got.seg) else begin
         fails++;
         $error("FAIL %s seg_n observed=%h expected=%h (n=%0d)", got.tag, seg_n, got.seg, n);
      end
      tests++;
      assert (an_n === got.an) else begin
         fails++;
         $error("FAIL %s an_n observed=%b expected=%b (n=%0d)", got.tag, an_n, got.an, n);
      end
      tests++;
      assert (dp_n === got.dp) else begin
         fails++;
         $error("FAIL %s dp_n observed=%b expected=%b (n=%0d)", got.tag, dp_n, got.dp, n);
      end
      tests++;
      assert (slot_tick === got.tick) else begin
         fails++;
         $error("FAIL %s slot_tick observed=%b expected=%b (n=%0d)", got.tag, slot_tick,
                got.tick, n);
      end
   endtask

   initial begin
      // 1: reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "reset");
      end

      // 2: decode sweep on digit0, digit1 fixed at 8
      for (int v = 0; v < 16; v++) begin
         step(1'b0, 1'b1, 4'(v), 4'd8, 1'b0, "sweep_latch");
         for (int c = 0; c < 2 * RDIV; c++) begin
            step(1'b0, 1'b0, 4'(v), 4'd8, 1'b0, "sweep");
         end
      end

      // 3: scan timing after a single latch
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "scan_rst");
      step(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, "scan_latch");
      for (int c = 0; c < 4 * RDIV; c++) begin
         step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "scan");
      end

      // 4: leading-zero blanking on and off
      step(1'b0, 1'b1, 4'd5, 4'd0, 1'b1, "lz_latch");
      for (int c = 0; c < 2 * RDIV; c++) begin
         step(1'b0, 1'b0, 4'd5, 4'd0, 1'b1, "lz_on");
      end
      for (int c = 0; c < 2 * RDIV; c++) begin
         step(1'b0, 1'b0, 4'd5, 4'd0, 1'b0, "lz_off");
      end

      // 5: shadow holds while latch is low, then a new latch
      step(1'b0, 1'b1, 4'd7, 4'd3, 1'b0, "hold_latch");
      for (int c = 0; c < 2 * RDIV; c++) begin
         step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, "hold");
      end
      while (!((((n + 1) / RDIV) % 2) == 0 && ((n + 1) % RDIV) >= BLANK)) begin
         step(1'b0, 1'b0, 4'd1, 4'd1, 1'b0, "hold_align");
      end
      step(1'b0, 1'b1, 4'd9, 4'd3, 1'b0, "relatch");
      for (int c = 0; c < RDIV; c++) begin
         step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "relatch_run");
      end

      // 6: reset mid digit1 slot, then latch exactly on the slot wrap
      while (!(((n / RDIV) % 2) == 1 && (n % RDIV) == 1)) begin
         step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "mid_align");
      end
      step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "mid_rst");
      step(1'b0, 1'b1, 4'd4, 4'd6, 1'b0, "post_rst_latch");
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "post_rst");
      step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "post_rst");
      step(1'b0, 1'b1, 4'd11, 4'd12, 1'b0, "wrap_latch");
      for (int c = 0; c < 2 * RDIV; c++) begin
         step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "wrap_run");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
